pdm_mic_tx: RTL and testbench

- PDM microphone-side transmitter; the other end of the sounddriver microphone capture path.
- Accepts PCM samples over a valid/ready interface, buffers them in a small FIFO, and converts each sample into OSR bits with a first-order sigma-delta modulator.
- Drives one PDM bit per edge of the mic clock generated by the receiver (micGenCLK).
- Serves as a synthesizable microphone stand-in for loopback benches and on-board self-test.

---
 rtl/pdm_mic_tx.sv | 152 +++++++++++++++
 tb/tb_pdm_mic_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_tx.sv
// pdm_mic_tx: microphone-side PDM transmitter.
// PCM samples are queued in a small FIFO. Each sample is expanded into OSR
// PDM bits by a first-order sigma-delta modulator. One bit is produced per
// active edge of the receiver-generated mic clock.
//
// Handshake: a sample transfers on any posedge where pcm_valid and pcm_ready
// are both high. pcm_ready is a registered "not full" flag and does not depend
// on pcm_valid in the same cycle. The producer may hold pcm_valid high for as
// long as it likes. Each cycle that has both signals high consumes one sample.
module pdm_mic_tx #(
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mic_clk,
  input  logic        lr_sel,
  input  logic [15:0] pcm_data,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  output logic        pdm_data,
  output logic        underflow
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(OSR - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  // mic_clk synchronizer and edge history
  logic s1_q, s2_q, s3_q;

  // FIFO storage and bookkeeping
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, ready_d;

  // Modulator state
  logic [15:0]   acc_q, acc_d;
  logic [15:0]   cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pdm_q, pdm_d;
  logic          uf_q, uf_d;

  logic          rise, fall, act_edge, reload, do_wr, do_pop;
  logic [16:0]   sum;

  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign act_edge = lr_sel ? rise : fall;
  assign reload   = enable & act_edge & (cnt_q == LAST_BIT);
  assign do_wr    = pcm_valid & ready_q;
  // A sample written this cycle only counts toward count_q next cycle,
  // so the pop decision never sees it. There is no bypass path.
  assign do_pop   = reload & (count_q != '0);
  // The carry out of the 17-bit sum is the PDM bit. The accumulator keeps
  // the residue, which gives the first-order error feedback.
  assign sum      = {1'b0, acc_q} + {1'b0, cur_q ^ 16'h8000};

  assign pcm_ready = ready_q;
  assign pdm_data  = pdm_q;
  assign underflow = uf_q;

  // Next-state for FIFO pointers, occupancy and the registered ready flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_wr && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_wr && do_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
    ready_d = (count_d != FULL_CNT);
  end

  // Next-state for the modulator, bit counter and sample reload
  always_comb begin
    acc_d = acc_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    pdm_d = pdm_q;
    uf_d  = 1'b0;
    if (!enable) begin
      acc_d = '0;
      cur_d = '0;
      cnt_d = '0;
      pdm_d = 1'b0;
    end else if (act_edge) begin
      acc_d = sum[15:0];
      pdm_d = sum[16];
      if (cnt_q == LAST_BIT) begin
        cnt_d = '0;
        if (count_q != '0) begin
          cur_d = mem_q[rd_ptr_q];
        end else begin
          uf_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      acc_q    <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      pdm_q    <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      s1_q     <= mic_clk;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      acc_q    <= acc_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      pdm_q    <= pdm_d;
      uf_q     <= uf_d;
    end
  end

  // FIFO data storage; the occupancy count alone defines validity, so no reset is needed
  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem_q[wr_ptr_q] <= pcm_data;
    end
  end

endmodule

// File: tb/tb_pdm_mic_tx.sv
// Testbench for pdm_mic_tx.
// The main process drives mic_clk and the PCM stream. At each active mic
// edge it asks a behavioural model for the expected {underflow, bit} pair
// and pushes that pair into exp_q. A separate monitor watches every mic_clk
// transition, samples the DUT once the update latency has elapsed, and pops
// exp_q to compare.
module tb_pdm_mic_tx;

  localparam int OSR   = 64;
  localparam int DEPTH = 4;
  localparam int H     = 12;  // clk cycles per mic_clk half period

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        mic_clk = 1'b0;
  logic        lr_sel = 1'b1;
  logic [15:0] pcm_data = '0;
  logic        pcm_valid = 1'b0;
  logic        pcm_ready;
  logic        pdm_data;
  logic        underflow;

  pdm_mic_tx #(.OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mic_clk  (mic_clk),
    .lr_sel   (lr_sel),
    .pcm_data (pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .pdm_data (pdm_data),
    .underflow(underflow)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Scoreboard and reference-model state
  logic [1:0]  exp_q[$];      // {underflow expected, pdm bit expected}
  logic [15:0] mq[$];         // model of the sample FIFO contents
  int          m_acc = 0;
  int          m_cnt = 0;
  logic [15:0] m_cur = '0;
  bit          m_en = 1'b1;
  logic        last_bit = 1'b0;
  bit          mon_on = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void chk(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Reference model: one PDM bit per active edge.
  // Density of ones = (sample + 32768) / 65536, produced by accumulating
  // and emitting the overflow.
  function automatic void model_edge();
    int  u;
    int  s;
    bit  b;
    bit  uf;
    uf = 1'b0;
    b  = 1'b0;
    if (m_en) begin
      u     = int'($signed(m_cur)) + 32768;
      s     = m_acc + u;
      b     = (s >= 65536);
      m_acc = s % 65536;
      if (m_cnt == OSR - 1) begin
        m_cnt = 0;
        if (mq.size() > 0) m_cur = mq.pop_front();
        else uf = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    exp_q.push_back({uf, b});
  endfunction

  function automatic void model_clear_mod();
    m_acc = 0;
    m_cnt = 0;
    m_cur = '0;
  endfunction

  // Driver: one mic_clk half period
  task automatic mic_step();
    @(negedge clk);
    mic_clk = ~mic_clk;
    if (lr_sel ? mic_clk : ~mic_clk) model_edge();
    repeat (H - 1) @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) mic_step();
  endtask

  task automatic to_low();
    if (mic_clk) mic_step();
  endtask

  // Driver: present one sample for one cycle, leaving pcm_valid high
  task automatic drive_one(input logic [15:0] d);
    @(negedge clk);
    pcm_valid = 1'b1;
    pcm_data  = d;
    chk("pcm_ready", 32'(pcm_ready), 32'(mq.size() < DEPTH));
    if (mq.size() < DEPTH) mq.push_back(d);
  endtask

  task automatic release_valid();
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic push_sample(input logic [15:0] d);
    drive_one(d);
    release_valid();
  endtask

  // Hold pcm_valid high for n consecutive cycles with random data
  task automatic burst(input int n);
    for (int i = 0; i < n; i++) drive_one(16'($urandom));
    release_valid();
  endtask

  // Pulse reset for one cycle; only called while mic_clk is low
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    model_clear_mod();
    last_bit = 1'b0;
    chk("reset_pdm", 32'(pdm_data), 32'd0);
    chk("reset_underflow", 32'(underflow), 32'd0);
    chk("reset_ready", 32'(pcm_ready), 32'd1);
  endtask

  task automatic set_enable(input logic v);
    @(negedge clk);
    enable = v;
    m_en   = v;
    model_clear_mod();
    if (!v) begin
      last_bit = 1'b0;
      @(negedge clk);
      chk("disable_pdm", 32'(pdm_data), 32'd0);
    end
  endtask

  // Monitor: compare after every mic_clk transition
  initial begin
    logic [1:0] e;
    bit         act;
    int         ufc;
    wait (mon_on);
    forever begin
      @(mic_clk);
      act = lr_sel ? mic_clk : ~mic_clk;
      ufc = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (k == 0) chk("pdm_early_hold", 32'(pdm_data), 32'(last_bit));
        if (underflow) ufc++;
      end
      if (act) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL exp_queue: got empty queue expected an entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pdm_bit", 32'(pdm_data), 32'(e[0]));
          chk("underflow_pulses", 32'(ufc), 32'(e[1]));
          last_bit = e[0];
        end
      end else begin
        chk("pdm_inactive_hold", 32'(pdm_data), 32'(last_bit));
        chk("underflow_inactive", 32'(ufc), 32'd0);
      end
    end
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Main stimulus
  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    mon_on = 1'b1;

    // Idle: midscale alternating bits, one underflow per OSR edges
    run(4 * OSR);

    // Full scale, negative full scale, zero
    push_sample(16'h7FFF);
    push_sample(16'h8000);
    push_sample(16'h0000);
    run(8 * OSR);

    // FIFO fills with mic_clk stopped, then one pop frees one slot
    burst(6);
    run(2 * OSR);
    burst(3);
    run(20);

    // Reset with samples buffered: everything discarded
    to_low();
    do_reset();
    push_sample(16'($urandom));
    push_sample(16'($urandom));
    push_sample(16'($urandom));
    run(20);
    to_low();
    do_reset();
    run(2 * OSR);

    // Enable drop during a 0x4000 sample
    push_sample(16'h4000);
    push_sample(16'($urandom));
    push_sample(16'($urandom));
    run(2 * OSR + 40);
    set_enable(1'b0);
    run(80);
    set_enable(1'b1);
    run(8 * OSR);

    // Falling-edge update mode
    to_low();
    lr_sel = 1'b0;
    push_sample(16'($urandom));
    push_sample(16'($urandom));
    push_sample(16'($urandom));
    run(8 * OSR);

    // Random traffic with occasional lr_sel changes while mic_clk is low
    for (int i = 0; i < 400; i++) begin
      mic_step();
      if ($urandom_range(0, 15) == 0) push_sample(16'($urandom));
      if (!mic_clk && $urandom_range(0, 31) == 0) lr_sel = ~lr_sel;
    end

    run(2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL exp_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
